// File: rtl/ltsm_pkg.sv
// Shared LTSM definitions: sideband message codes, MBTRAIN exit encoding,
// LINKSPEED initiator state type and its debug view.
package ltsm_pkg;

  localparam logic [3:0] SB_START_REQ          = 4'd1;
  localparam logic [3:0] SB_START_RESP         = 4'd2;
  localparam logic [3:0] SB_ERROR_REQ          = 4'd3;
  localparam logic [3:0] SB_ERROR_RESP         = 4'd4;
  localparam logic [3:0] SB_REPAIR_REQ         = 4'd5;
  localparam logic [3:0] SB_REPAIR_RESP        = 4'd6;
  localparam logic [3:0] SB_SPEED_DEGRADE_REQ  = 4'd7;
  localparam logic [3:0] SB_SPEED_DEGRADE_RESP = 4'd8;
  localparam logic [3:0] SB_DONE_REQ           = 4'd9;
  localparam logic [3:0] SB_DONE_RESP          = 4'd10;
  localparam logic [3:0] SB_PHYRETRAIN_REQ     = 4'd11;
  localparam logic [3:0] SB_PHYRETRAIN_RESP    = 4'd12;

  localparam logic [1:0] EXIT_DONE       = 2'b00;
  localparam logic [1:0] EXIT_REPAIR     = 2'b01;
  localparam logic [1:0] EXIT_DEGRADE    = 2'b10;
  localparam logic [1:0] EXIT_PHYRETRAIN = 2'b11;

  typedef enum logic [3:0] {
    LS_IDLE,
    LS_SEND_START,
    LS_WAIT_START_RESP,
    LS_POINT_TEST,
    LS_SEND_RESULT,
    LS_WAIT_RESULT_RESP,
    LS_SEND_EXIT,
    LS_WAIT_EXIT_RESP,
    LS_TEST_FINISH
  } ls_state_e;

  typedef struct packed {
    ls_state_e state;
    logic      pending;
  } ls_dbg_t;

  // A lane half passes only if the half is usable and all 8 of its lanes passed.
  function automatic logic half_pass(input logic usable, input logic [7:0] res);
    return usable & (&res);
  endfunction

endpackage

// File: rtl/sb_valid_ctrl.sv
// Sideband TX request handshake: raises valid once the shared port is free,
// holds a pending request while linkspeed_rx owns it, drops on busy negedge.
module sb_valid_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic load,
  input  logic rx_valid,
  input  logic busy_negedge,
  output logic valid_tx,
  output logic pending
);

  // Handshake: load is a 1-cycle pulse per message. valid_tx asserts when a
  // request exists and rx_valid is low, stays high until busy_negedge, and
  // busy_negedge beats a same-cycle set (the request then stays pending).
  logic req;
  logic set;

  assign req = load | pending;
  assign set = req & ~rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_tx <= 1'b0;
      pending  <= 1'b0;
    end else if (flush) begin
      valid_tx <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (busy_negedge) valid_tx <= 1'b0;
      else if (set)     valid_tx <= 1'b1;
      pending <= req & ~(set & ~busy_negedge);
    end
  end

endmodule

// File: rtl/linkspeed_tx.sv
// MBTRAIN.LINKSPEED initiator: start/result/exit request sequence and exit decision.
// Optional response-wait timeout enabled by defining LINKSPEED_TX_TIMEOUT_EN.
module linkspeed_tx
  import ltsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [3:0]  i_sideband_message,
  input  logic        i_sideband_valid,
  input  logic        i_rx_valid,
  input  logic        i_busy_negedge_detected,
  input  logic        i_point_test_ack,
  input  logic [15:0] i_lanes_result,
  input  logic        i_valid_framing_error,
  input  logic        i_phyretrain_req,
  input  logic        i_comming_from_repair,
  input  logic        i_first_8_tx_lanes_are_functional,
  input  logic        i_second_8_tx_lanes_are_functional,
  output logic [3:0]  o_sideband_message,
  output logic        o_valid_tx,
  output logic        o_point_test_en,
  output logic        o_test_ack,
  output logic [1:0]  o_exit,
`ifdef LINKSPEED_TX_TIMEOUT_EN
  output logic        o_timeout,
`endif
  output ls_dbg_t     dbg
);

  ls_state_e   state, state_n;
  logic [3:0]  msg_n;
  logic        pt_en_n, ack_n, load_q, load_n;
  logic [1:0]  exit_n;
  logic [15:0] lanes_q, lanes_n;
  logic        valid_d, tx_fall, pending;
  logic [3:0]  result_msg;
  logic        timeout_n;

  assign tx_fall = valid_d & ~o_valid_tx;

  // Lanes [7:0] form the first half, [15:8] the second half.
  always_comb begin
    result_msg = SB_ERROR_REQ;
    if (i_phyretrain_req)
      result_msg = SB_PHYRETRAIN_REQ;
    else if ((&i_lanes_result) && !i_valid_framing_error)
      result_msg = SB_DONE_REQ;
    else if (i_comming_from_repair &&
             (half_pass(i_first_8_tx_lanes_are_functional, i_lanes_result[7:0]) ||
              half_pass(i_second_8_tx_lanes_are_functional, i_lanes_result[15:8])))
      result_msg = SB_DONE_REQ;
  end

`ifdef LINKSPEED_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          waiting, tmo_hit;

  assign waiting = (state == LS_WAIT_START_RESP) || (state == LS_POINT_TEST) ||
                   (state == LS_WAIT_RESULT_RESP) || (state == LS_WAIT_EXIT_RESP);
  assign tmo_hit = waiting && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           tmo_cnt <= '0;
    else if (!waiting || state_n != state) tmo_cnt <= '0;
    else                                  tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_n   = state;
    msg_n     = o_sideband_message;
    pt_en_n   = o_point_test_en;
    ack_n     = 1'b0;
    exit_n    = o_exit;
    load_n    = 1'b0;
    lanes_n   = lanes_q;
    timeout_n = 1'b0;
    if (!i_en) begin
      state_n = LS_IDLE;
      msg_n   = 4'd0;
      pt_en_n = 1'b0;
      exit_n  = EXIT_DONE;
    end else begin
      case (state)
        LS_IDLE: begin
          state_n = LS_SEND_START;
          msg_n   = SB_START_REQ;
          load_n  = 1'b1;
        end
        LS_SEND_START:
          if (tx_fall) state_n = LS_WAIT_START_RESP;
        LS_WAIT_START_RESP:
          if (i_sideband_valid && i_sideband_message == SB_START_RESP) begin
            state_n = LS_POINT_TEST;
            pt_en_n = 1'b1;
          end
        LS_POINT_TEST:
          if (i_point_test_ack) begin
            state_n = LS_SEND_RESULT;
            pt_en_n = 1'b0;
            msg_n   = result_msg;
            load_n  = 1'b1;
            lanes_n = i_lanes_result;
          end
        LS_SEND_RESULT:
          if (tx_fall) state_n = LS_WAIT_RESULT_RESP;
        LS_WAIT_RESULT_RESP:
          if (i_sideband_valid) begin
            case (i_sideband_message)
              SB_DONE_RESP: begin
                state_n = LS_TEST_FINISH;
                exit_n  = EXIT_DONE;
              end
              SB_PHYRETRAIN_RESP: begin
                state_n = LS_TEST_FINISH;
                exit_n  = EXIT_PHYRETRAIN;
              end
              SB_ERROR_RESP: begin
                state_n = LS_SEND_EXIT;
                msg_n   = ((&lanes_q[7:0]) || (&lanes_q[15:8])) ? SB_REPAIR_REQ
                                                                 : SB_SPEED_DEGRADE_REQ;
                load_n  = 1'b1;
              end
              default: ;
            endcase
          end
        LS_SEND_EXIT:
          if (tx_fall) state_n = LS_WAIT_EXIT_RESP;
        LS_WAIT_EXIT_RESP:
          if (i_sideband_valid) begin
            if (o_sideband_message == SB_REPAIR_REQ &&
                i_sideband_message == SB_REPAIR_RESP) begin
              state_n = LS_TEST_FINISH;
              exit_n  = EXIT_REPAIR;
            end else if (o_sideband_message == SB_SPEED_DEGRADE_REQ &&
                         i_sideband_message == SB_SPEED_DEGRADE_RESP) begin
              state_n = LS_TEST_FINISH;
              exit_n  = EXIT_DEGRADE;
            end
          end
        LS_TEST_FINISH:
          ack_n = 1'b1;
        default:
          state_n = LS_IDLE;
      endcase
`ifdef LINKSPEED_TX_TIMEOUT_EN
      if (tmo_hit) begin
        state_n   = LS_TEST_FINISH;
        exit_n    = EXIT_DEGRADE;
        pt_en_n   = 1'b0;
        timeout_n = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= LS_IDLE;
      o_sideband_message <= 4'd0;
      o_point_test_en    <= 1'b0;
      o_test_ack         <= 1'b0;
      o_exit             <= EXIT_DONE;
      load_q             <= 1'b0;
      lanes_q            <= 16'd0;
      valid_d            <= 1'b0;
    end else begin
      state              <= state_n;
      o_sideband_message <= msg_n;
      o_point_test_en    <= pt_en_n;
      o_test_ack         <= ack_n;
      o_exit             <= exit_n;
      load_q             <= load_n;
      lanes_q            <= lanes_n;
      valid_d            <= i_en & o_valid_tx;
    end
  end

`ifdef LINKSPEED_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_timeout <= 1'b0;
    else        o_timeout <= timeout_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout_n;
`endif

  sb_valid_ctrl u_valid_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (~i_en),
    .load         (load_q),
    .rx_valid     (i_rx_valid),
    .busy_negedge (i_busy_negedge_detected),
    .valid_tx     (o_valid_tx),
    .pending      (pending)
  );

  assign dbg.state   = state;
  assign dbg.pending = pending;

endmodule

// File: tb/tb_linkspeed_tx.sv
// Directed bench for linkspeed_tx: table of full handshakes plus hand-written
// arbitration, busy-collision and abort sequences.
module tb_linkspeed_tx;
  import ltsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  sb_msg = 4'd0;
  logic        sb_valid = 1'b0;
  logic        rx_valid = 1'b0;
  logic        busy_neg = 1'b0;
  logic        pt_ack = 1'b0;
  logic [15:0] lanes = 16'd0;
  logic        ferr = 1'b0;
  logic        phy = 1'b0;
  logic        from_rep = 1'b0;
  logic        f8 = 1'b0;
  logic        s8 = 1'b0;
  logic [3:0]  o_sideband_message;
  logic        o_valid_tx, o_point_test_en, o_test_ack;
  logic [1:0]  o_exit;
  ls_dbg_t     dbg;
`ifdef LINKSPEED_TX_TIMEOUT_EN
  logic        o_timeout;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  linkspeed_tx dut (
    .clk                                (clk),
    .rst_n                              (rst_n),
    .i_en                               (en),
    .i_sideband_message                 (sb_msg),
    .i_sideband_valid                   (sb_valid),
    .i_rx_valid                         (rx_valid),
    .i_busy_negedge_detected            (busy_neg),
    .i_point_test_ack                   (pt_ack),
    .i_lanes_result                     (lanes),
    .i_valid_framing_error              (ferr),
    .i_phyretrain_req                   (phy),
    .i_comming_from_repair              (from_rep),
    .i_first_8_tx_lanes_are_functional  (f8),
    .i_second_8_tx_lanes_are_functional (s8),
    .o_sideband_message                 (o_sideband_message),
    .o_valid_tx                         (o_valid_tx),
    .o_point_test_en                    (o_point_test_en),
    .o_test_ack                         (o_test_ack),
    .o_exit                             (o_exit),
`ifdef LINKSPEED_TX_TIMEOUT_EN
    .o_timeout                          (o_timeout),
`endif
    .dbg                                (dbg)
  );

  typedef struct {
    logic [15:0] lanes;
    logic        ferr, phy, from_rep, f8, s8;
    logic [3:0]  exp_result;
    logic [3:0]  exp_exit_msg;
    logic [1:0]  exp_exit;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Response code for a request code.
  function automatic logic [3:0] resp_for(input logic [3:0] req);
    return req + 4'd1;
  endfunction

  // Wait for a transmit request, check its code, then play the serializer.
  task automatic tx_expect(input string name, input logic [3:0] exp_msg);
    int n = 0;
    while (!o_valid_tx && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s valid_tx", name), {31'd0, o_valid_tx}, 32'd1);
    check($sformatf("%s message", name), {28'd0, o_sideband_message}, {28'd0, exp_msg});
    busy_neg = 1'b1;
    @(negedge clk);
    busy_neg = 1'b0;
    check($sformatf("%s valid_tx drop", name), {31'd0, o_valid_tx}, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic respond(input logic [3:0] m);
    sb_msg   = m;
    sb_valid = 1'b1;
    @(negedge clk);
    sb_valid = 1'b0;
    sb_msg   = 4'd0;
  endtask

  task automatic clear_inputs();
    lanes = 16'd0; ferr = 1'b0; phy = 1'b0; from_rep = 1'b0; f8 = 1'b0; s8 = 1'b0;
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    en = 1'b1;
    @(negedge clk);
    tx_expect($sformatf("v%0d start", idx), SB_START_REQ);
    respond(SB_START_RESP);
    check($sformatf("v%0d pt_en set", idx), {31'd0, o_point_test_en}, 32'd1);
    lanes = v.lanes; ferr = v.ferr; phy = v.phy;
    from_rep = v.from_rep; f8 = v.f8; s8 = v.s8;
    pt_ack = 1'b1;
    @(negedge clk);
    pt_ack = 1'b0;
    check($sformatf("v%0d pt_en clear", idx), {31'd0, o_point_test_en}, 32'd0);
    tx_expect($sformatf("v%0d result", idx), v.exp_result);
    respond(resp_for(v.exp_result));
    if (v.exp_result == SB_ERROR_REQ) begin
      tx_expect($sformatf("v%0d exit req", idx), v.exp_exit_msg);
      respond(resp_for(v.exp_exit_msg));
    end
    check($sformatf("v%0d exit early", idx), {30'd0, o_exit}, {30'd0, v.exp_exit});
    check($sformatf("v%0d ack not yet", idx), {31'd0, o_test_ack}, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d ack", idx), {31'd0, o_test_ack}, 32'd1);
    check($sformatf("v%0d exit", idx), {30'd0, o_exit}, {30'd0, v.exp_exit});
    en = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d ack drop", idx), {31'd0, o_test_ack}, 32'd0);
    check($sformatf("v%0d exit clear", idx), {30'd0, o_exit}, 32'd0);
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // lanes, ferr, phy, from_rep, f8, s8, result, exit req, exit code
    vecs[0]  = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB_DONE_REQ,       4'd0, EXIT_DONE};
    vecs[1]  = '{16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB_ERROR_REQ,      SB_REPAIR_REQ, EXIT_REPAIR};
    vecs[2]  = '{16'h7F7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB_ERROR_REQ,      SB_SPEED_DEGRADE_REQ, EXIT_DEGRADE};
    vecs[3]  = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SB_ERROR_REQ,      SB_REPAIR_REQ, EXIT_REPAIR};
    vecs[4]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SB_PHYRETRAIN_REQ, 4'd0, EXIT_PHYRETRAIN};
    vecs[5]  = '{16'h00FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, SB_DONE_REQ,       4'd0, EXIT_DONE};
    vecs[6]  = '{16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SB_ERROR_REQ,      SB_REPAIR_REQ, EXIT_REPAIR};
    vecs[7]  = '{16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SB_DONE_REQ,       4'd0, EXIT_DONE};
    vecs[8]  = '{16'h7F7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SB_PHYRETRAIN_REQ, 4'd0, EXIT_PHYRETRAIN};
    vecs[9]  = '{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SB_ERROR_REQ,      SB_REPAIR_REQ, EXIT_REPAIR};
    vecs[10] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, SB_ERROR_REQ,      SB_SPEED_DEGRADE_REQ, EXIT_DEGRADE};

    // Reset state
    #12;
    check("reset message", {28'd0, o_sideband_message}, 32'd0);
    check("reset valid_tx", {31'd0, o_valid_tx}, 32'd0);
    check("reset pt_en", {31'd0, o_point_test_en}, 32'd0);
    check("reset ack", {31'd0, o_test_ack}, 32'd0);
    check("reset exit", {30'd0, o_exit}, 32'd0);
    check("reset state", {28'd0, dbg.state}, {28'd0, LS_IDLE});
    check("reset pending", {31'd0, dbg.pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vector(i, vecs[i]);

    // Earliest valid and ignored non-matching response
    en = 1'b1;
    @(negedge clk);
    check("early message", {28'd0, o_sideband_message}, {28'd0, SB_START_REQ});
    check("early valid low", {31'd0, o_valid_tx}, 32'd0);
    @(negedge clk);
    check("early valid high", {31'd0, o_valid_tx}, 32'd1);
    tx_expect("early", SB_START_REQ);
    respond(SB_DONE_RESP);
    check("ignored resp", {31'd0, o_point_test_en}, 32'd0);
    respond(SB_START_RESP);
    check("start resp after ignore", {31'd0, o_point_test_en}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("abort pt_en", {31'd0, o_point_test_en}, 32'd0);
    @(negedge clk);

    // Arbitration: linkspeed_rx owns the port for 5 cycles
    en = 1'b1;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("arb hold %0d", i), {31'd0, o_valid_tx}, 32'd0);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check("arb release", {31'd0, o_valid_tx}, 32'd1);
    tx_expect("arb", SB_START_REQ);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Busy negedge coinciding with the set: clear wins, request stays pending
    en = 1'b1;
    @(negedge clk);
    busy_neg = 1'b1;
    @(negedge clk);
    busy_neg = 1'b0;
    check("collision valid low", {31'd0, o_valid_tx}, 32'd0);
    check("collision pending", {31'd0, dbg.pending}, 32'd1);
    @(negedge clk);
    check("collision valid later", {31'd0, o_valid_tx}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Abort in WAIT_RESULT_RESP, then restart
    en = 1'b1;
    @(negedge clk);
    tx_expect("abort start", SB_START_REQ);
    respond(SB_START_RESP);
    lanes = 16'hFFFF;
    pt_ack = 1'b1;
    @(negedge clk);
    pt_ack = 1'b0;
    tx_expect("abort result", SB_DONE_REQ);
    check("abort in wait", {28'd0, dbg.state}, {28'd0, LS_WAIT_RESULT_RESP});
    en = 1'b0;
    @(negedge clk);
    check("abort state", {28'd0, dbg.state}, {28'd0, LS_IDLE});
    check("abort message", {28'd0, o_sideband_message}, 32'd0);
    check("abort valid", {31'd0, o_valid_tx}, 32'd0);
    check("abort pt", {31'd0, o_point_test_en}, 32'd0);
    check("abort ack", {31'd0, o_test_ack}, 32'd0);
    check("abort exit", {30'd0, o_exit}, 32'd0);
    clear_inputs();
    en = 1'b1;
    @(negedge clk);
    tx_expect("restart", SB_START_REQ);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
